// File: rtl/sipo_pkg.sv
// Shared constants for the serial frame receiver: FSM state encoding and line levels.
package sipo_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit MSB-first shift register with shift enable and async active-high clear.
module sipo_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= '0;
    else if (en) q <= {q[WIDTH-2:0], din};
  end
endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, stop bit; valid/ack holding register.
// Define SIPO_FRAME_RX_PARITY_EN to expect an even-parity bit before the stop bit (adds perr).
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sft,
  input  logic             sin,
  input  logic             ack,
  output logic [WIDTH-1:0] qrx,
  output logic             dvalid,
  output logic             busy,
  output logic             ferr,
`ifdef SIPO_FRAME_RX_PARITY_EN
  output logic             perr,
`endif
  output logic             ovr
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam logic [1:0] ST_AFTER_DATA = ST_PAR;
`else
  localparam logic [1:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic [1:0]       state, nstate;
  logic [CW-1:0]    cnt, ncnt;
  logic [WIDTH-1:0] shreg;
  logic             last, good_stop, bad_stop, load;

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk (clk),
    .clr (clr),
    .en  (sft && (state == ST_DATA)),
    .din (sin),
    .q   (shreg)
  );

  assign last      = (cnt == CW'(WIDTH - 1));
  assign busy      = (state != ST_IDLE);
  assign good_stop = sft && (state == ST_STOP) && (sin == STOP_BIT);
  assign bad_stop  = sft && (state == ST_STOP) && (sin != STOP_BIT);
  // A pending word blocks the load unless the consumer acks on this very edge.
  assign load      = good_stop && (!dvalid || ack);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    if (sft) begin
      case (state)
        ST_IDLE: if (sin == START_BIT) begin
          nstate = ST_DATA;
          ncnt   = '0;
        end
        ST_DATA: begin
          if (last) nstate = ST_AFTER_DATA;
          else      ncnt   = cnt + CW'(1);
        end
        ST_PAR:  nstate = ST_STOP;
        // a low stop bit returns to IDLE without being taken as a start bit
        default: nstate = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      qrx    <= '0;
      dvalid <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (load) qrx <= shreg;
      dvalid <= (dvalid && !ack) || load;
      ovr    <= (ovr && !ack) || (good_stop && dvalid && !ack);
      ferr   <= (ferr && !ack) || bad_stop;
    end
  end

`ifdef SIPO_FRAME_RX_PARITY_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) perr <= 1'b0;
    else     perr <= (perr && !ack) || (sft && (state == ST_PAR) && (^{shreg, sin}));
  end
`endif
endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: scenario tasks with a queue of expected received words.
module tb_sipo_frame_rx;
  localparam int WIDTH = 4;
`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam int NB = WIDTH + 2;
`else
  localparam int NB = WIDTH + 1;
`endif

  logic clk = 1'b0;
  logic clr, sft, sin, ack;
  logic [WIDTH-1:0] qrx;
  logic dvalid, busy, ferr, ovr;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic perr;
`endif

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] exp_w;

  sipo_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .clr    (clr),
    .sft    (sft),
    .sin    (sin),
    .ack    (ack),
    .qrx    (qrx),
    .dvalid (dvalid),
    .busy   (busy),
    .ferr   (ferr),
`ifdef SIPO_FRAME_RX_PARITY_EN
    .perr   (perr),
`endif
    .ovr    (ovr)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (busy) busy_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bitx(input logic b, input logic a, input int gap);
    @(negedge clk);
    sft = 1'b1; sin = b; ack = a;
    repeat (gap) begin
      @(negedge clk);
      sft = 1'b0; sin = ~sin; ack = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sft = 1'b0; sin = 1'b1; ack = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    sft = 1'b0; sin = 1'b1; ack = 1'b1;
    idle();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop, input int gap,
                            input logic ack_stop, input logic par);
    bitx(1'b0, 1'b0, gap);
    for (int i = WIDTH - 1; i >= 0; i--) bitx(d[i], 1'b0, gap);
`ifdef SIPO_FRAME_RX_PARITY_EN
    bitx(par, 1'b0, gap);
`endif
    bitx(stop, ack_stop, gap);
    idle();
  endtask

  task automatic check_word(input string nm);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: qrx=%b but no word expected", nm, qrx);
    end else begin
      exp_w = sb.pop_front();
      if (qrx !== exp_w) begin
        failures++;
        $display("FAIL %s: qrx=%b expected %b", nm, qrx, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; sft = 1'b0; sin = 1'b1; ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({qrx, dvalid, busy, ferr, ovr} !== '0) begin
      failures++;
      $display("FAIL reset: qrx=%b dv=%b busy=%b ferr=%b ovr=%b expected all 0", qrx, dvalid, busy, ferr, ovr);
    end
`ifdef SIPO_FRAME_RX_PARITY_EN
    checks++;
    if (perr !== 1'b0) begin failures++; $display("FAIL reset_perr: perr=%b expected 0", perr); end
`endif
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bitx(1'b0, 1'b0, 0);
    bitx(1'b1, 1'b0, 0);
    bitx(1'b0, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midframe_busy: busy=%b expected 1", busy); end
    clr = 1'b1; sft = 1'b0; sin = 1'b1;
    #1;
    checks++;
    if ({qrx, dvalid, busy, ferr, ovr} !== '0) begin
      failures++;
      $display("FAIL midframe_clr: qrx=%b dv=%b busy=%b ferr=%b ovr=%b expected all 0", qrx, dvalid, busy, ferr, ovr);
    end
    @(negedge clk);
    clr = 1'b0;
    sb.push_back(4'b1001);
    send_frame(4'b1001, 1'b1, 0, 1'b0, 1'b0);
    checks++;
    if (dvalid !== 1'b1) begin failures++; $display("FAIL midframe_after_dv: dvalid=%b expected 1", dvalid); end
    check_word("midframe_after_q");
    pulse_ack();
  endtask

  task automatic test_good_frame();
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b1);
    checks++;
    if (dvalid !== 1'b1) begin failures++; $display("FAIL good_dv: dvalid=%b expected 1", dvalid); end
    check_word("good_q");
    pulse_ack();
    checks++;
    if ({dvalid, qrx} !== {1'b0, 4'b1011}) begin
      failures++;
      $display("FAIL good_ack: dvalid=%b qrx=%b expected 0 1011", dvalid, qrx);
    end
  endtask

  task automatic test_sft_gating();
    busy_cnt = 0;
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 2, 1'b0, 1'b1);
    checks++;
    if (busy_cnt !== 3 * NB) begin failures++; $display("FAIL gate_busy: busy cycles=%0d expected %0d", busy_cnt, 3 * NB); end
    checks++;
    if (dvalid !== 1'b1) begin failures++; $display("FAIL gate_dv: dvalid=%b expected 1", dvalid); end
    check_word("gate_q");
    pulse_ack();
  endtask

  task automatic test_framing();
    send_frame(4'b1100, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if ({ferr, dvalid, qrx, busy} !== {1'b1, 1'b0, 4'b1011, 1'b0}) begin
      failures++;
      $display("FAIL frame_err: ferr=%b dv=%b qrx=%b busy=%b expected 1 0 1011 0", ferr, dvalid, qrx, busy);
    end
    idle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL frame_nostart: busy=%b expected 0", busy); end
    pulse_ack();
    checks++;
    if (ferr !== 1'b0) begin failures++; $display("FAIL frame_ack: ferr=%b expected 0", ferr); end
  endtask

  task automatic test_overrun();
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b1);
    check_word("ovr_first_q");
    send_frame(4'b0110, 1'b1, 0, 1'b0, 1'b0);
    checks++;
    if ({ovr, dvalid, qrx} !== {1'b1, 1'b1, 4'b1011}) begin
      failures++;
      $display("FAIL ovr_set: ovr=%b dv=%b qrx=%b expected 1 1 1011", ovr, dvalid, qrx);
    end
    sb.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 0, 1'b1, 1'b0);
    checks++;
    if ({ovr, dvalid} !== 2'b01) begin
      failures++;
      $display("FAIL ovr_ackload: ovr=%b dv=%b expected 0 1", ovr, dvalid);
    end
    check_word("ovr_ackload_q");
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    a = 4'b1110; b = 4'b0001;
    sb.push_back(a);
    sb.push_back(b);
    bitx(1'b0, 1'b0, 0);
    for (int i = WIDTH - 1; i >= 0; i--) bitx(a[i], 1'b0, 0);
`ifdef SIPO_FRAME_RX_PARITY_EN
    bitx(^a, 1'b0, 0);
`endif
    bitx(1'b1, 1'b0, 0);
    @(negedge clk);
    check_word("b2b_first_q");
    sft = 1'b1; sin = 1'b0; ack = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) bitx(b[i], (i == WIDTH - 1), 0);
`ifdef SIPO_FRAME_RX_PARITY_EN
    bitx(^b, 1'b0, 0);
`endif
    bitx(1'b1, 1'b0, 0);
    idle();
    checks++;
    if ({dvalid, ovr} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_flags: dv=%b ovr=%b expected 1 0", dvalid, ovr);
    end
    check_word("b2b_second_q");
    pulse_ack();
  endtask

`ifdef SIPO_FRAME_RX_PARITY_EN
  task automatic test_parity();
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b1);
    checks++;
    if (perr !== 1'b0) begin failures++; $display("FAIL par_good: perr=%b expected 0", perr); end
    check_word("par_good_q");
    pulse_ack();
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0);
    checks++;
    if ({perr, dvalid} !== 2'b11) begin failures++; $display("FAIL par_bad: perr=%b dv=%b expected 1 1", perr, dvalid); end
    check_word("par_bad_q");
    pulse_ack();
    checks++;
    if (perr !== 1'b0) begin failures++; $display("FAIL par_ack: perr=%b expected 0", perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midframe();
    test_good_frame();
    test_sft_gating();
    test_framing();
    test_overrun();
    test_back_to_back();
`ifdef SIPO_FRAME_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d words left, expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
